// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for the shared data-memory port: core (A) vs DMA (B).
// Optional performance counters are enabled with `define DMEM_ARB_PERF_EN.
module dmem_arbiter #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MAX_HOLD = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    output logic          a_gnt,
    output logic          a_rvalid,
    output logic [DW-1:0] a_rdata,
    output logic          core_stall,
    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    input  logic          b_lock,
    output logic          b_gnt,
    output logic          b_rvalid,
    output logic [DW-1:0] b_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
`ifdef DMEM_ARB_PERF_EN
    ,
    input  logic          perf_clr,
    output logic [31:0]   perf_conflict,
    output logic [31:0]   perf_a_stall
`endif
);

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_A,
        OWN_B
    } owner_t;

    localparam logic       WIN_A      = 1'b0;
    localparam logic       WIN_B      = 1'b1;
    localparam logic [7:0] MAX_HOLD_L = 8'(MAX_HOLD);

    logic       last_win;
    logic [7:0] hold_cnt;
    owner_t     rd_owner;
    logic       a_win;
    logic       b_win;

    // Grants are gated by reset so every output reads 0 while rst is low.
    always_comb begin
        a_win = 1'b0;
        b_win = 1'b0;
        if (rst) begin
            if (a_req && b_req) begin
                if (b_lock && (last_win == WIN_B) && (hold_cnt < MAX_HOLD_L))
                    b_win = 1'b1;
                else if (last_win == WIN_B)
                    a_win = 1'b1;
                else
                    b_win = 1'b1;
            end else if (a_req) begin
                a_win = 1'b1;
            end else if (b_req) begin
                b_win = 1'b1;
            end
        end
    end

    assign a_gnt      = a_win;
    assign b_gnt      = b_win;
    assign core_stall = rst & a_req & ~a_win;

    assign mem_en    = a_win | b_win;
    assign mem_we    = a_win ? a_we    : (b_win ? b_we    : 1'b0);
    assign mem_addr  = a_win ? a_addr  : (b_win ? b_addr  : '0);
    assign mem_wdata = a_win ? a_wdata : (b_win ? b_wdata : '0);

    assign a_rvalid = (rd_owner == OWN_A);
    assign b_rvalid = (rd_owner == OWN_B);
    assign a_rdata  = a_rvalid ? mem_rdata : '0;
    assign b_rdata  = b_rvalid ? mem_rdata : '0;

    // An unlocked B grant ends any lock sequence, so it clears the hold count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_win <= WIN_B;
            hold_cnt <= 8'd0;
            rd_owner <= OWN_NONE;
        end else begin
            if (a_win)
                last_win <= WIN_A;
            else if (b_win)
                last_win <= WIN_B;

            if (a_win) begin
                hold_cnt <= 8'd0;
            end else if (b_win) begin
                if (!b_lock)
                    hold_cnt <= 8'd0;
                else if (a_req && (hold_cnt != 8'hFF))
                    hold_cnt <= hold_cnt + 8'd1;
            end

            if (a_win && !a_we)
                rd_owner <= OWN_A;
            else if (b_win && !b_we)
                rd_owner <= OWN_B;
            else
                rd_owner <= OWN_NONE;
        end
    end

`ifdef DMEM_ARB_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_conflict <= 32'd0;
            perf_a_stall  <= 32'd0;
        end else if (perf_clr) begin
            perf_conflict <= 32'd0;
            perf_a_stall  <= 32'd0;
        end else begin
            if (a_req && b_req && (perf_conflict != 32'hFFFF_FFFF))
                perf_conflict <= perf_conflict + 32'd1;
            if (core_stall && (perf_a_stall != 32'hFFFF_FFFF))
                perf_a_stall <= perf_a_stall + 32'd1;
        end
    end
`endif

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter for the single shared data-memory port.
- Requester A is the core load/store path. Requester B is a DMA/program-loader engine.
- Grants at most one access per cycle and drives the memory port. Routes read data back to the winner.
- Produces the core stall that freezes the PC while the core loses arbitration.
- Sits between the core memory stage, the DMA engine and the data memory.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- MAX_HOLD, 8, maximum consecutive B grants under dma_lock while A is waiting (1..255).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- a_req  in  1  core access request.
- a_we  in  1  core write enable (1 = write, 0 = read).
- a_addr  in  AW  core byte address.
- a_wdata  in  DW  core write data.
- a_gnt  out  1  core access accepted this cycle.
- a_rvalid  out  1  core read data valid.
- a_rdata  out  DW  core read data.
- core_stall  out  1  equals a_req & ~a_gnt.
- b_req  in  1  DMA access request.
- b_we  in  1  DMA write enable.
- b_addr  in  AW  DMA byte address.
- b_wdata  in  DW  DMA write data.
- b_lock  in  1  DMA requests back-to-back grants.
- b_gnt  out  1  DMA access accepted this cycle.
- b_rvalid  out  1  DMA read data valid.
- b_rdata  out  DW  DMA read data.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write strobe.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data, valid 1 cycle after a read strobe.

Behaviour:
- Reset: rst low, asynchronous.
  - All outputs 0. last_win=B (so A wins the first conflict). hold_cnt=0. rd_owner=NONE.
  - Any in-flight rvalid is discarded and never emitted after reset release.
- State registers:
  - last_win, 1 bit.
  - hold_cnt, 8 bits, saturating.
  - rd_owner (NONE/A/B), the pending-read tag.
- Grant decision is combinational, same cycle as req:
  - Only A requests: A wins.
  - Only B requests: B wins.
  - Both request, with b_lock=1, last_win=B and hold_cnt<MAX_HOLD: B wins (lock hold).
  - Both request, otherwise: the requester that is not last_win wins (round-robin).
  - Neither requests: no grant, mem_en=0.
- At most one of a_gnt/b_gnt is high in any cycle.
- When a grant is given: mem_en=1, and mem_we/mem_addr/mem_wdata are muxed from the winner in the same cycle.
- Writes complete at grant. No rvalid is produced for a write.
- Reads:
  - A granted read sets rd_owner to the winner at the clock edge.
  - Next cycle: the owner's rvalid=1 and its rdata=mem_rdata. The other requester's rdata is held at 0.
  - rvalid is a single-cycle pulse. Back-to-back reads pipeline at full rate, one per cycle.
- last_win updates to the winner on every granted cycle. It holds on idle cycles.
- hold_cnt:
  - Increments when B wins while a_req=1.
  - Clears when A wins, or when b_lock=0 and B wins.
  - Holds otherwise.
  - Once hold_cnt=MAX_HOLD, A wins the next conflict. The count then clears.
- Requesters must keep req/we/addr/wdata stable until gnt. Dropping req before gnt is legal and cancels the access.
- core_stall is combinational. With no B activity it is 0, giving zero added latency for the core.

Optional Feature:
- Macro: DMEM_ARB_PERF_EN.
- When defined:
  - Adds outputs perf_conflict (32 bits) and perf_a_stall (32 bits), plus input perf_clr (1 bit).
  - perf_conflict counts cycles with a_req & b_req.
  - perf_a_stall counts cycles with core_stall=1.
  - Both counters saturate at 0xFFFFFFFF. Both clear on reset or perf_clr=1; perf_clr takes priority over increment.
- When undefined: none of these ports or registers exist. Arbitration behaviour is identical.

Test Plan:
- Reset, then a read by A alone:
  - rst low with a_req=1: all outputs 0.
  - Release rst, then a_req=1, a_we=0, a_addr=0x10 with memory holding 0xDEADBEEF: a_gnt=1 and mem_addr=0x10 that cycle; a_rvalid=1 and a_rdata=0xDEADBEEF next cycle; core_stall=0 throughout.
- Simultaneous requests, no lock, 6 cycles:
  - Grants alternate A,B,A,B,A,B.
  - core_stall is high on cycles 2, 4 and 6.
- Lock hold with MAX_HOLD=8:
  - Setup: b_lock=1, B holds the grant, A requests continuously.
  - Response: B is granted exactly 8 consecutive conflict cycles, then A is granted once, then B resumes.
- Back-to-back reads, B then A:
  - B reads 0x20 in cycle n and A reads 0x24 in cycle n+1.
  - b_rvalid is high only in n+1 and a_rvalid only in n+2, each with the correct data and the other rvalid low.
- Write:
  - B writes 0x55AA to 0x40: mem_we=1 for one cycle and no rvalid follows.
  - A then reads 0x40 and gets 0x55AA.
- Reset mid-read:
  - Assert rst the cycle after an A read grant.
  - a_rvalid never pulses and rd_owner=NONE after release.
